fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Pipeline IF stage plus IF/ID register; feeds the decode-stage controller (op/funct3/funct7b5 come from InstrD) and consumes the controller's PCSrcE redirect together with PCTargetE.
- Owns PCF and a single-outstanding ready/valid request port to instruction memory.
- Absorbs variable imem latency and decode backpressure; inserts NOP bubbles.
- Discards stale responses after a taken branch or jump.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- StallD  input  1  decode not accepting; IF/ID holds.
- FlushD  input  1  load bubble into IF/ID; wins over StallD.
- PCSrcE  input  1  redirect request from the EX stage.
- PCTargetE  input  32  redirect target.
- imem_req  output  1  request valid.
- imem_addr  output  32  request address (word-aligned).
- imem_ready  input  1  request accepted this cycle when imem_req=1.
- imem_rvalid  input  1  response valid; never earlier than 1 cycle after acceptance.
- imem_rdata  input  32  response instruction.
- InstrD  output  32  IF/ID instruction.
- PCD  output  32  IF/ID PC.
- PCPlus4D  output  32  IF/ID PC+4.
- ValidD  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst_n=0 at edge): PCF=RESET_PC, state=S_REQ, hold buffer invalid, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. imem_req forced 0 while rst_n=0.
- imem_req=1 only in S_REQ; imem_addr=PCF always (combinational).
- S_REQ: on imem_ready go to S_WAIT; otherwise stay in S_REQ with the address held stable.
- S_WAIT: on imem_rvalid:
  - if StallD=0: transfer (InstrD=imem_rdata, PCD=PCF, PCPlus4D=PCF+4, ValidD=1), PCF+=4, go to S_REQ.
  - if StallD=1: capture imem_rdata in the hold buffer, go to S_HOLD.
- S_HOLD: when StallD=0, transfer the held instruction (as above), PCF+=4, go to S_REQ. No re-request of the same address.
- S_DRAIN: waiting for a stale response. On imem_rvalid, discard the data and go to S_REQ.
- Redirect (PCSrcE=1) has top priority. PCF<=PCTargetE; no PCF+=4 and no transfer that cycle. Next state by current state:
  - S_REQ with imem_ready=0: stay in S_REQ.
  - S_REQ with imem_ready=1: request already accepted for the old PC, go to S_DRAIN.
  - S_WAIT with imem_rvalid=0: go to S_DRAIN.
  - S_WAIT with imem_rvalid=1: drop the data, go to S_REQ.
  - S_HOLD: drop the buffer, go to S_REQ.
  - S_DRAIN: stay in S_DRAIN, or go to S_REQ if imem_rvalid=1.
- IF/ID update priority per edge: FlushD > StallD (hold all fields) > transfer > bubble (InstrD=NOP_INSTR, ValidD=0; PCD and PCPlus4D hold). FlushD writes NOP_INSTR, ValidD=0, PCD=0, PCPlus4D=0.
- Hazard unit asserts FlushD with PCSrcE; this block does not self-flush.
- Throughput: best case 1 instruction per 2 cycles (REQ accepted, rvalid next cycle). Exactly one outstanding request.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 wraps to 0.
- imem_rvalid in S_REQ or S_HOLD is a protocol violation; flag it with an assertion, and the data is ignored.
- Reset mid-transaction returns to S_REQ; a response arriving after reset is ignored until a new request is accepted (assertion only, no drain).

Decomposition:
- riscv_pkg: fetch_state_t enum {S_REQ, S_WAIT, S_HOLD, S_DRAIN}; NOP_INSTR constant; XLEN=32.
- Sub-module if_id_reg: enable/clear register carrying InstrD, PCD, PCPlus4D, ValidD; clear has priority over enable.
- FSM, PCF, and hold buffer stay in fetch_stage.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> imem_req=0, InstrD=0x00000013, ValidD=0; first cycle after release imem_req=1, imem_addr=0x0.
- Straight-line fetch: imem_ready=1, rvalid 1 cycle later, rdata=0x00500093 -> InstrD=0x00500093, PCD=0x0, PCPlus4D=0x4, ValidD=1; next imem_addr=0x4.
- Stall: rvalid with StallD=1 for 3 cycles -> IF/ID unchanged, no imem_req; StallD=0 -> held instruction lands next edge, then imem_addr=PC+4.
- Redirect in S_WAIT: PCSrcE=1, PCTargetE=0x40, FlushD=1; rvalid 2 cycles later with 0xDEADBEEF -> discarded, ValidD=0; next imem_addr=0x40.
- Redirect coincident with rvalid: data dropped, ValidD=0, next cycle imem_req=1 at 0x40. Redirect coincident with imem_ready -> S_DRAIN, the following rvalid is discarded.
- Backpressure: imem_ready=0 for 3 cycles -> imem_req held at 1, imem_addr stable, ValidD=0 bubbles; wrap test with PCF=0xFFFF_FFFC -> PCPlus4D=0x0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage and its IF/ID register.
// No logic lives here.
// Not applicable.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

  // One IF/ID pipeline slot.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with enable and clear; clear wins over enable.
// Latency: one cycle from d to q.
// Backpressure: en=0 holds every field unchanged.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = riscv_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  en,
  input  ifid_t d,
  output ifid_t q
);

  localparam ifid_t CLR_VAL = '{instr: NOP, pc: '0, pcplus4: '0, valid: 1'b0};

  // Pipeline slot: reset and clear load a bubble, enable loads the next slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= CLR_VAL;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: owns PCF, issues one imem request at a time, drops stale data.
// Latency: best case 2 cycles per instruction (request accepted, response next cycle).
// Backpressure: StallD parks a fetched instruction in a hold buffer; imem_ready=0 holds the request.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  fetch_state_t    state_q, state_n;
  logic [XLEN-1:0] pcf_q, pcf_n;
  logic [XLEN-1:0] hold_q;
  logic            hold_vld_q;
  logic            hold_load;
  logic            xfer;
  logic [XLEN-1:0] xfer_instr;
  ifid_t           ifid_d, ifid_q;

  assign imem_req  = rst_n && (state_q == S_REQ);
  assign imem_addr = pcf_q;

  // Next state, next PC and transfer decision; a redirect overrides everything else.
  always_comb begin
    state_n    = state_q;
    pcf_n      = pcf_q;
    xfer       = 1'b0;
    xfer_instr = hold_q;
    hold_load  = 1'b0;
    if (PCSrcE) begin
      pcf_n = PCTargetE;
      case (state_q)
        S_REQ:   state_n = imem_ready  ? S_DRAIN : S_REQ;
        S_WAIT:  state_n = imem_rvalid ? S_REQ   : S_DRAIN;
        S_HOLD:  state_n = S_REQ;
        S_DRAIN: state_n = imem_rvalid ? S_REQ   : S_DRAIN;
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_ready) state_n = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (!StallD) begin
              xfer       = 1'b1;
              xfer_instr = imem_rdata;
              pcf_n      = pcf_q + 32'd4;
              state_n    = S_REQ;
            end else begin
              hold_load = 1'b1;
              state_n   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // The held word is already fetched, so no re-request of this PC.
          if (!StallD) begin
            xfer    = 1'b1;
            pcf_n   = pcf_q + 32'd4;
            state_n = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_n = S_REQ;
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  // State and program counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pcf_q   <= RESET_PC;
    end else begin
      state_q <= state_n;
      pcf_q   <= pcf_n;
    end
  end

  // Hold buffer: captures a response that decode could not take.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      if (hold_load) hold_q <= imem_rdata;
      hold_vld_q <= (state_n == S_HOLD);
    end
  end

  // Transfer loads a real instruction; otherwise a bubble that keeps the PC fields.
  assign ifid_d = xfer ? '{instr: xfer_instr, pc: pcf_q, pcplus4: pcf_q + 32'd4, valid: 1'b1}
                       : '{instr: NOP_INSTR, pc: ifid_q.pc, pcplus4: ifid_q.pcplus4, valid: 1'b0};

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (FlushD),
    .en    (!StallD),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pcplus4;
  assign ValidD   = ifid_q.valid;

  // A response is only legal while a request is outstanding (S_WAIT or S_DRAIN).
  a_no_stray_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (state_q == S_REQ || state_q == S_HOLD)));

  // S_HOLD is only ever entered with a captured word.
  a_hold_valid : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_HOLD) |-> hold_vld_q);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          ndeliv = 0;
  // Memory side model: at most one accepted request awaiting its response.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          cnt = 0;
  int          lat = 0;
  logic        use_ovr = 1'b0;
  logic [31:0] ovr_dat = 32'h0;
  // Program-order model: PC of the next instruction decode should see.
  logic [31:0] exp_pc = 32'h0;

  // Instruction memory contents: distinct word per address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    PCSrcE      = 1'b0;
    PCTargetE   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_valid", 32'(ValidD), 32'h0);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pcplus4", PCPlus4D, 32'h0);
    rst_n  = 1'b1;
    pend   = 1'b0;
    cnt    = 0;
    exp_pc = 32'h0;
    #1;
    chk("rel_req", 32'(imem_req), 32'h1);
    chk("rel_addr", imem_addr, 32'h0);
  endtask

  // One clock cycle: drive inputs, check request side, clock, check IF/ID against program order.
  task automatic cyc(input logic rdy, input logic stall, input logic flush,
                     input logic pcsrc, input logic [31:0] tgt);
    logic        rv, req_s;
    logic [31:0] addr_s, i_q, p_q, p4_q;
    logic        v_q;
    rv          = pend && (cnt == 0);
    imem_ready  = rdy;
    imem_rvalid = rv;
    imem_rdata  = rv ? (use_ovr ? ovr_dat : mem(pend_addr)) : $urandom;
    StallD      = stall;
    FlushD      = flush;
    PCSrcE      = pcsrc;
    PCTargetE   = tgt;
    req_s  = imem_req;
    addr_s = imem_addr;
    i_q = InstrD; p_q = PCD; p4_q = PCPlus4D; v_q = ValidD;
    if (req_s) begin
      chk("req_addr", addr_s, exp_pc);
      chk("one_outstanding", 32'(pend), 32'h0);
    end
    @(posedge clk);
    #1;
    if (rv) pend = 1'b0;
    else if (pend) cnt--;
    if (req_s && rdy) begin
      pend      = 1'b1;
      pend_addr = addr_s;
      cnt       = lat;
    end
    if (flush) begin
      chk("flush_instr", InstrD, NOP);
      chk("flush_valid", 32'(ValidD), 32'h0);
      chk("flush_pcd", PCD, 32'h0);
      chk("flush_pcplus4", PCPlus4D, 32'h0);
    end else if (stall) begin
      chk("stall_instr", InstrD, i_q);
      chk("stall_valid", 32'(ValidD), 32'(v_q));
      chk("stall_pcd", PCD, p_q);
      chk("stall_pcplus4", PCPlus4D, p4_q);
    end else if (ValidD) begin
      chk("deliv_pcd", PCD, exp_pc);
      chk("deliv_instr", InstrD, mem(exp_pc));
      chk("deliv_pcplus4", PCPlus4D, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      ndeliv++;
    end else begin
      chk("bubble_instr", InstrD, NOP);
      chk("bubble_pcd", PCD, p_q);
      chk("bubble_pcplus4", PCPlus4D, p4_q);
    end
    if (pcsrc) exp_pc = tgt;
  endtask

  initial begin
    do_reset();

    // Straight-line fetch, response one cycle after acceptance.
    lat = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("sl_instr", InstrD, 32'h0050_0093);
    chk("sl_pcd", PCD, 32'h0);
    chk("sl_pcplus4", PCPlus4D, 32'h4);
    chk("sl_valid", 32'(ValidD), 32'h1);
    chk("sl_next_addr", imem_addr, 32'h4);

    // Response arrives under stall, held for 3 cycles.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_no_req", 32'(imem_req), 32'h0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("held_valid", 32'(ValidD), 32'h1);
    chk("held_pcd", PCD, 32'h4);
    chk("held_next_req", 32'(imem_req), 32'h1);
    chk("held_next_addr", imem_addr, 32'h8);

    // Redirect while waiting; stale response two cycles after acceptance.
    lat = 1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    chk("drain_no_req", 32'(imem_req), 32'h0);
    use_ovr = 1'b1;
    ovr_dat = 32'hDEAD_BEEF;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    use_ovr = 1'b0;
    chk("stale_valid", 32'(ValidD), 32'h0);
    chk("stale_instr", InstrD, NOP);
    chk("redir_req", 32'(imem_req), 32'h1);
    chk("redir_addr", imem_addr, 32'h40);

    // Redirect coincident with rvalid.
    lat = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    chk("rv_redir_valid", 32'(ValidD), 32'h0);
    chk("rv_redir_req", 32'(imem_req), 32'h1);
    chk("rv_redir_addr", imem_addr, 32'h80);

    // Redirect coincident with imem_ready.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'hC0);
    chk("rdy_redir_no_req", 32'(imem_req), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rdy_redir_valid", 32'(ValidD), 32'h0);
    chk("rdy_redir_req", 32'(imem_req), 32'h1);
    chk("rdy_redir_addr", imem_addr, 32'hC0);

    // Memory backpressure.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("bp_req", 32'(imem_req), 32'h1);
      chk("bp_addr", imem_addr, 32'hC0);
      chk("bp_valid", 32'(ValidD), 32'h0);
    end

    // PC wrap-around.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", PCPlus4D, 32'h0);
    chk("wrap_valid", 32'(ValidD), 32'h1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Randomized traffic with a reset in the middle.
    ndeliv = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r, s, j;
      if (i == 1500) do_reset();
      lat = $urandom_range(0, 3);
      r   = ($urandom_range(0, 2) != 0);
      s   = ($urandom_range(0, 3) == 0);
      j   = ($urandom_range(0, 15) == 0);
      cyc(r, s, j, j, $urandom & 32'hFFFF_FFFC);
    end
    chk("progress", 32'(ndeliv > 300), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
